// File: rtl/player_damage.sv
// Contact damage for the player: once per frame tick, scan every enemy slot for hitbox
// overlap, then apply the accumulated damage, with invulnerability frames after a hit.
module player_damage #(
   parameter int ENEMY_NUM     = 8,
   parameter int PLAYER_SIZE   = 26,
   parameter int ENEMY_SIZE    = 26,
   parameter int DAMAGE        = 10,
   parameter int INVULN_FRAMES = 30,
   parameter int MAX_BLOOD     = 100
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   frame_clk,
   input  logic [8:0]             Player_X,
   input  logic [8:0]             Player_Y,
   input  logic [9*ENEMY_NUM-1:0] Enemy_X_All,
   input  logic [9*ENEMY_NUM-1:0] Enemy_Y_All,
   input  logic [ENEMY_NUM-1:0]   Enemy_Alive,
   output logic [6:0]             Player_Blood,
   output logic                   Player_Alive,
   output logic                   Invincible,
   output logic                   Hit_Pulse,
   output logic                   Game_Over
);
   localparam int IDX_W  = (ENEMY_NUM > 1) ? $clog2(ENEMY_NUM) : 1;
   localparam int HITS_W = $clog2(ENEMY_NUM + 1);
   localparam int INV_W  = $clog2(INVULN_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, SCAN, APPLY, DEAD} state_t;

   state_t             r_state, w_state_nxt;
   logic               r_fc_d1, r_fc_d2;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [HITS_W-1:0]  r_hits, w_hits_nxt;
   logic [INV_W-1:0]   r_invuln, w_invuln_nxt;
   logic [6:0]         r_blood, w_blood_nxt;
   logic               r_alive, r_invinc, r_pulse, r_game_over, w_pulse_nxt;
   logic               w_tick, w_hit;
   logic [8:0]         w_ex_arr [ENEMY_NUM];
   logic [8:0]         w_ey_arr [ENEMY_NUM];
   logic [9:0]         w_ex, w_ey, w_px, w_py;
   logic [15:0]        w_total;
   logic [6:0]         w_blood_hit;

   genvar g;
   generate
      for (g = 0; g < ENEMY_NUM; g++) begin : g_unpack
         assign w_ex_arr[g] = Enemy_X_All[9*g +: 9];
         assign w_ey_arr[g] = Enemy_Y_All[9*g +: 9];
      end
   endgenerate

   // frame_clk comes from another clock domain; the two flops double as sync and edge detect
   assign w_tick = r_fc_d1 & ~r_fc_d2;

   // 10-bit compares so a hitbox near the 511 edge cannot wrap into a false miss
   assign w_ex  = {1'b0, w_ex_arr[r_idx]};
   assign w_ey  = {1'b0, w_ey_arr[r_idx]};
   assign w_px  = {1'b0, Player_X};
   assign w_py  = {1'b0, Player_Y};
   assign w_hit = Enemy_Alive[r_idx]
                  && (w_ex + 10'(ENEMY_SIZE) >= w_px) && (w_ex <= w_px + 10'(PLAYER_SIZE))
                  && (w_ey + 10'(ENEMY_SIZE) >= w_py) && (w_ey <= w_py + 10'(PLAYER_SIZE));

   assign w_total     = 16'(r_hits) * 16'(DAMAGE);
   assign w_blood_hit = (w_total >= {9'd0, r_blood}) ? 7'd0 : r_blood - w_total[6:0];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_hits_nxt   = r_hits;
      w_invuln_nxt = r_invuln;
      w_blood_nxt  = r_blood;
      w_pulse_nxt  = 1'b0;
      case (r_state)
         IDLE: if (w_tick) begin
            w_state_nxt = SCAN;
            w_idx_nxt   = '0;
            w_hits_nxt  = '0;
            if (r_invuln != '0) w_invuln_nxt = r_invuln - INV_W'(1);
         end
         SCAN: begin
            if (w_hit) w_hits_nxt = r_hits + HITS_W'(1);
            if (r_idx == IDX_W'(ENEMY_NUM - 1)) w_state_nxt = APPLY;
            else                                w_idx_nxt   = r_idx + IDX_W'(1);
         end
         APPLY: begin
            if (r_hits != '0 && r_invuln == '0) begin
               w_blood_nxt  = w_blood_hit;
               w_invuln_nxt = INV_W'(INVULN_FRAMES);
               w_pulse_nxt  = 1'b1;
            end
            w_state_nxt = (w_blood_nxt == 7'd0) ? DEAD : IDLE;
         end
         default: w_state_nxt = DEAD;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_fc_d1     <= 1'b0;
         r_fc_d2     <= 1'b0;
         r_idx       <= '0;
         r_hits      <= '0;
         r_invuln    <= '0;
         r_blood     <= 7'(MAX_BLOOD);
         r_alive     <= 1'b1;
         r_invinc    <= 1'b0;
         r_pulse     <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_fc_d1     <= frame_clk;
         r_fc_d2     <= r_fc_d1;
         r_idx       <= w_idx_nxt;
         r_hits      <= w_hits_nxt;
         r_invuln    <= w_invuln_nxt;
         r_blood     <= w_blood_nxt;
         r_alive     <= (w_blood_nxt != 7'd0);
         r_invinc    <= (w_invuln_nxt != '0) && (w_state_nxt != DEAD);
         r_pulse     <= w_pulse_nxt;
         r_game_over <= (w_state_nxt == DEAD);
      end
   end

   assign Player_Blood = r_blood;
   assign Player_Alive = r_alive;
   assign Invincible   = r_invinc;
   assign Hit_Pulse    = r_pulse;
   assign Game_Over    = r_game_over;
endmodule

// File: tb/tb_player_damage.sv
// Directed bench for player_damage: reset, hit latency, invulnerability, masks,
// overlap boundaries, death and asynchronous reset.
module tb_player_damage;
   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_clk = 1'b0;
   logic [8:0]  Player_X = 9'd110, Player_Y = 9'd110;
   logic [71:0] Enemy_X_All = '0, Enemy_Y_All = '0;
   logic [7:0]  Enemy_Alive = '0;
   logic [6:0]  Player_Blood;
   logic        Player_Alive, Invincible, Hit_Pulse, Game_Over;
   int          vectors = 0, miscompares = 0;

   player_damage dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
      .Player_X(Player_X), .Player_Y(Player_Y),
      .Enemy_X_All(Enemy_X_All), .Enemy_Y_All(Enemy_Y_All), .Enemy_Alive(Enemy_Alive),
      .Player_Blood(Player_Blood), .Player_Alive(Player_Alive), .Invincible(Invincible),
      .Hit_Pulse(Hit_Pulse), .Game_Over(Game_Over)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_enemy(input int i, input logic [8:0] x, input logic [8:0] y);
      Enemy_X_All[9*i +: 9] = x;
      Enemy_Y_All[9*i +: 9] = y;
   endtask

   task automatic park_all();
      for (int i = 0; i < 8; i++) set_enemy(i, 9'd400, 9'd400);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   // one full frame: rising edge, then enough cycles for scan + apply to finish
   task automatic frame();
      @(negedge Clk) frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (11) @(negedge Clk);
   endtask

   initial begin
      park_all();
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("reset_blood", Player_Blood, 100);
      chk("reset_alive", Player_Alive, 1);
      chk("reset_invinc", Invincible, 0);
      chk("reset_pulse", Hit_Pulse, 0);
      chk("reset_gameover", Game_Over, 0);

      // single hit with exact latency
      set_enemy(3, 9'd100, 9'd100);
      Enemy_Alive = 8'h08;
      @(negedge Clk) frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (7) @(negedge Clk);
      chk("hit_blood_before", Player_Blood, 100);
      chk("hit_pulse_before", Hit_Pulse, 0);
      @(negedge Clk);
      chk("hit_blood", Player_Blood, 90);
      chk("hit_pulse", Hit_Pulse, 1);
      chk("hit_invinc", Invincible, 1);
      @(negedge Clk);
      chk("hit_pulse_drop", Hit_Pulse, 0);
      repeat (3) @(negedge Clk);

      // invulnerability window
      for (int k = 1; k <= 29; k++) begin
         frame();
         chk($sformatf("invuln_tick%0d", k), Player_Blood, 90);
      end
      chk("invuln_still_set", Invincible, 1);
      frame();
      chk("invuln_tick30", Player_Blood, 80);

      // multi-hit with alive mask
      do_reset();
      park_all();
      set_enemy(0, 9'd100, 9'd100);
      set_enemy(2, 9'd120, 9'd90);
      set_enemy(5, 9'd110, 9'd130);
      set_enemy(6, 9'd110, 9'd110);
      Enemy_Alive = 8'h25;
      frame();
      chk("multi_blood", Player_Blood, 70);

      // boundaries, all on enemy 0 only
      park_all();
      Enemy_Alive = 8'h01;
      Player_X = 9'd100; Player_Y = 9'd100;
      do_reset(); set_enemy(0, 9'd126, 9'd100); frame();
      chk("bnd_x_plus26", Player_Blood, 90);
      do_reset(); set_enemy(0, 9'd127, 9'd100); frame();
      chk("bnd_x_plus27", Player_Blood, 100);
      do_reset(); set_enemy(0, 9'd74, 9'd100); frame();
      chk("bnd_x_minus26", Player_Blood, 90);
      do_reset(); set_enemy(0, 9'd73, 9'd100); frame();
      chk("bnd_x_minus27", Player_Blood, 100);
      do_reset(); set_enemy(0, 9'd100, 9'd127); frame();
      chk("bnd_y_plus27", Player_Blood, 100);
      do_reset(); Player_X = 9'd500; set_enemy(0, 9'd490, 9'd100); frame();
      chk("bnd_nowrap", Player_Blood, 90);

      // death: 8 hits -> 20, then 3 hits after invulnerability expires
      do_reset();
      Player_X = 9'd110; Player_Y = 9'd110;
      for (int i = 0; i < 8; i++) set_enemy(i, 9'd110, 9'd110);
      Enemy_Alive = 8'hFF;
      frame();
      chk("death_pre_blood", Player_Blood, 20);
      Enemy_Alive = 8'h07;
      for (int k = 1; k <= 29; k++) frame();
      chk("death_invuln_hold", Player_Blood, 20);
      frame();
      chk("death_blood", Player_Blood, 0);
      chk("death_gameover", Game_Over, 1);
      chk("death_alive", Player_Alive, 0);
      chk("death_invinc", Invincible, 0);
      Enemy_Alive = 8'hFF;
      frame();
      chk("dead_blood", Player_Blood, 0);
      chk("dead_gameover", Game_Over, 1);
      chk("dead_pulse", Hit_Pulse, 0);

      // asynchronous reset out of DEAD
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_dead_blood", Player_Blood, 100);
      chk("rst_dead_gameover", Game_Over, 0);
      chk("rst_dead_alive", Player_Alive, 1);
      @(negedge Clk) Reset_n = 1'b1;
      @(negedge Clk);

      // first tick after release is a normal tick
      Enemy_Alive = 8'h08;
      frame();
      chk("post_rst_hit", Player_Blood, 90);

      // reset mid-SCAN
      @(negedge Clk) frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_scan_blood", Player_Blood, 100);
      chk("rst_scan_gameover", Game_Over, 0);
      chk("rst_scan_invinc", Invincible, 0);
      @(negedge Clk) Reset_n = 1'b1;
      repeat (14) @(negedge Clk);
      chk("rst_scan_no_apply", Player_Blood, 100);
      frame();
      chk("rst_scan_next_hit", Player_Blood, 90);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
